// File: rtl/pio_event_streamer.sv
// pio_event_streamer: debounced PIO input snapshots, buffered and framed as Avalon-ST byte packets.
// Optional: define PIO_EVT_TIMESTAMP_EN to append a 16-bit capture timestamp (LSB, MSB) to each packet.
module pio_event_streamer #(
    parameter int unsigned IN_W         = 5,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [IN_W-1:0]               pio_in,
    input  logic                          snap_req,
    input  logic                          sto_ready,
    output logic                          sto_valid,
    output logic [7:0]                    sto_data,
    output logic                          sto_startofpacket,
    output logic                          sto_endofpacket,
    output logic                          sto_reset_o,
    output logic [IN_W-1:0]               pio_stable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned NB = (IN_W + 7) / 8;
    localparam int unsigned PAD_W = NB * 8;
`ifdef PIO_EVT_TIMESTAMP_EN
    localparam int unsigned EW = IN_W + 16;
    localparam int unsigned NBEATS = NB + 2;
`else
    localparam int unsigned EW = IN_W;
    localparam int unsigned NBEATS = NB;
`endif
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(NBEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBEATS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    // ---------------- input synchroniser and debounce ----------------
    logic [IN_W-1:0]             sync1_q, sync2_q;
    logic [IN_W-1:0]             stable_q, stable_d;
    logic [IN_W-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                        chg_q, snap_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < IN_W; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
            snap_q   <= 1'b0;
        end else begin
            sync1_q  <= pio_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= |(stable_d ^ stable_q);
            snap_q   <= snap_req;
        end
    end

    // ---------------- snapshot FIFO ----------------
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [EW-1:0]    wr_entry;
    logic             push, pop, full, empty, push_ok, drop;
    logic             ovf_q, ovf_d;

    // A change and a snapshot request landing together collapse into one entry.
    assign push    = chg_q | snap_q;
    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign ovf_d   = drop ? 1'b1 : (pop ? 1'b0 : ovf_q);

`ifdef PIO_EVT_TIMESTAMP_EN
    logic [15:0] ts_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) ts_q <= '0;
        else             ts_q <= ts_q + 16'd1;
    end

    assign wr_entry = {ts_q, stable_q};
`else
    assign wr_entry = stable_q;
`endif

    always_ff @(posedge clk_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            ovf_q <= ovf_d;
        end
    end

    // ---------------- transmit FSM ----------------
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seq_q, seq_d;
    logic [7:0]         hdr_q, hdr_d;
    logic [EW-1:0]      pkt_q, pkt_d;
    logic               valid_q, valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [7:0]         data_q, data_d;
    logic               rst_out_q;
    logic               accept;
    logic [NBEATS*8-1:0] payload;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        hdr_d   = hdr_q;
        pkt_d   = pkt_q;
        pop     = 1'b0;
        accept  = valid_q && sto_ready;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hdr_d   = {ovf_q, seq_q};
                    pkt_d   = mem_q[rd_ptr_q];
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        seq_d   = seq_q + 7'd1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PIO_EVT_TIMESTAMP_EN
        payload = {pkt_d[EW-1 -: 16], PAD_W'(pkt_d[IN_W-1:0])};
`else
        payload = PAD_W'(pkt_d);
`endif

        // Outputs are registered from next state so they hold while stalled.
        valid_d = (state_d != StIdle);
        sop_d   = (state_d == StHdr);
        eop_d   = (state_d == StData) && (idx_d == IDX_LAST);
        data_d  = '0;
        if (state_d == StHdr) begin
            data_d = hdr_d;
        end else if (state_d == StData) begin
            for (int b = 0; b < NBEATS; b++) begin
                if (idx_d == IDX_W'(b)) data_d = payload[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            seq_q   <= '0;
            hdr_q   <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            hdr_q   <= hdr_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        rst_out_q <= reset_reset;
    end

    assign sto_valid         = valid_q;
    assign sto_data          = data_q;
    assign sto_startofpacket = sop_q;
    assign sto_endofpacket   = eop_q;
    assign sto_reset_o       = rst_out_q;
    assign pio_stable        = stable_q;
    assign fifo_level        = level_q;

endmodule

// File: tb/tb_pio_event_streamer.sv
// Directed self-checking bench for pio_event_streamer (IN_W=5, DEBOUNCE_CYC=4, FIFO_DEPTH=4).
module tb_pio_event_streamer;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [4:0] pio_in;
    logic       snap_req;
    logic       sto_ready;
    logic       sto_valid;
    logic [7:0] sto_data;
    logic       sto_startofpacket;
    logic       sto_endofpacket;
    logic       sto_reset_o;
    logic [4:0] pio_stable;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Accepted beats as {sop, eop, data}.
    logic [9:0] beats[$];
    logic [7:0] hdrs[$];

    always #5 clk_clk = ~clk_clk;

    pio_event_streamer #(
        .IN_W        (5),
        .DEBOUNCE_CYC(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .pio_in           (pio_in),
        .snap_req         (snap_req),
        .sto_ready        (sto_ready),
        .sto_valid        (sto_valid),
        .sto_data         (sto_data),
        .sto_startofpacket(sto_startofpacket),
        .sto_endofpacket  (sto_endofpacket),
        .sto_reset_o      (sto_reset_o),
        .pio_stable       (pio_stable),
        .fifo_level       (fifo_level)
    );

    always @(negedge clk_clk) begin
        #2;
        if (sto_valid && sto_ready && !reset_reset)
            beats.push_back({sto_startofpacket, sto_endofpacket, sto_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        pio_in      = '0;
        snap_req    = 1'b0;
        sto_ready   = 1'b0;
        tick(2);
        reset_reset = 1'b0;
        beats.delete();
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!sto_valid && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, 32'(sto_valid), 32'd1);
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k = 0;
        while (beats.size() < n && k < 2000) begin
            tick(1);
            k++;
        end
        check(tag, 32'(beats.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [9:0] exp4 [10];
        exp4 = '{10'h200, 10'h101, 10'h281, 10'h102, 10'h202,
                 10'h103, 10'h203, 10'h104, 10'h204, 10'h105};

        // Reset state
        do_reset();
        check("rst_valid", 32'(sto_valid), 32'd0);
        check("rst_sop", 32'(sto_startofpacket), 32'd0);
        check("rst_eop", 32'(sto_endofpacket), 32'd0);
        check("rst_data", 32'(sto_data), 32'h00);
        check("rst_stable", 32'(pio_stable), 32'h00);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_out_hi", 32'(sto_reset_o), 32'd1);
        tick(1);
        check("rst_out_lo", 32'(sto_reset_o), 32'd0);

        // 1: debounced change -> one packet, latency E / E+1 / E+2
        sto_ready = 1'b1;
        pio_in    = 5'b00101;
        k = 0;
        while (pio_stable != 5'h05 && k < 20) begin
            tick(1);
            k++;
        end
        check("s1_stable", 32'(pio_stable), 32'h05);
        check("s1_e_level", 32'(fifo_level), 32'd0);
        tick(1);
        check("s1_e1_level", 32'(fifo_level), 32'd1);
        check("s1_e1_valid", 32'(sto_valid), 32'd0);
        tick(1);
        check("s1_e2_valid", 32'(sto_valid), 32'd1);
        check("s1_e2_sop", 32'(sto_startofpacket), 32'd1);
        check("s1_e2_level", 32'(fifo_level), 32'd0);
        wait_beats("s1_beats", 2);
        tick(6);
        check("s1_only2", 32'(beats.size()), 32'd2);
        check("s1_hdr", 32'(beats[0]), 32'h200);
        check("s1_data", 32'(beats[1]), 32'h105);
        pulse_snap();
        wait_beats("s1_snap_beats", 4);
        check("s1_hdr2", 32'(beats[2]), 32'h201);
        check("s1_data2", 32'(beats[3]), 32'h105);

        // 2: glitch shorter than debounce window
        do_reset();
        sto_ready = 1'b1;
        pio_in    = 5'b00001;
        tick(3);
        pio_in = 5'b00000;
        tick(12);
        check("s2_stable", 32'(pio_stable), 32'h00);
        check("s2_level", 32'(fifo_level), 32'd0);
        check("s2_nobeats", 32'(beats.size()), 32'd0);
        check("s2_valid", 32'(sto_valid), 32'd0);

        // 3: back-pressure pattern 0,0,1,0,1
        do_reset();
        pio_in = 5'b10010;
        wait_valid("s3_valid");
        check("s3_hdr_c0", 32'({sto_startofpacket, sto_data}), 32'h100);
        tick(1);
        check("s3_hdr_c1", 32'({sto_valid, sto_startofpacket, sto_data}), 32'h300);
        sto_ready = 1'b1;
        tick(1);
        sto_ready = 1'b0;
        check("s3_dat_c2", 32'({sto_startofpacket, sto_endofpacket, sto_data}), 32'h112);
        tick(1);
        check("s3_dat_c3", 32'({sto_valid, sto_endofpacket, sto_data}), 32'h312);
        sto_ready = 1'b1;
        tick(1);
        sto_ready = 1'b0;
        check("s3_idle", 32'(sto_valid), 32'd0);
        tick(5);
        check("s3_nbeats", 32'(beats.size()), 32'd2);
        check("s3_beat0", 32'(beats[0]), 32'h200);
        check("s3_beat1", 32'(beats[1]), 32'h112);

        // 4: overflow with ready held low
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            pio_in = 5'(v);
            tick(9);
        end
        check("s4_stable", 32'(pio_stable), 32'h06);
        check("s4_level", 32'(fifo_level), 32'd4);
        check("s4_hold_hdr", 32'({sto_valid, sto_startofpacket, sto_data}), 32'h300);
        sto_ready = 1'b1;
        wait_beats("s4_beats", 10);
        tick(10);
        check("s4_nbeats", 32'(beats.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("s4_beat%0d", i), 32'(beats[i]), 32'(exp4[i]));
        check("s4_level_end", 32'(fifo_level), 32'd0);

        // 5: sequence number wrap
        do_reset();
        sto_ready = 1'b1;
        for (int i = 0; i < 129; i++) begin
            pulse_snap();
            tick(7);
        end
        wait_beats("s5_beats", 258);
        hdrs.delete();
        foreach (beats[i]) if (beats[i][9]) hdrs.push_back(beats[i][7:0]);
        check("s5_npkts", 32'(hdrs.size()), 32'd129);
        check("s5_hdr1", 32'(hdrs[0]), 32'h00);
        check("s5_hdr2", 32'(hdrs[1]), 32'h01);
        check("s5_hdr128", 32'(hdrs[127]), 32'h7F);
        check("s5_hdr129", 32'(hdrs[128]), 32'h00);

        // 6: reset during a DATA beat
        do_reset();
        pio_in = 5'b01001;
        wait_valid("s6_valid");
        pulse_snap();
        tick(2);
        pulse_snap();
        tick(3);
        check("s6_level_pre", 32'(fifo_level), 32'd2);
        sto_ready = 1'b1;
        tick(1);
        sto_ready = 1'b0;
        check("s6_in_data", 32'({sto_valid, sto_startofpacket, sto_endofpacket}), 32'h5);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        beats.delete();
        check("s6_valid_lo", 32'(sto_valid), 32'd0);
        check("s6_eop_lo", 32'(sto_endofpacket), 32'd0);
        check("s6_rst_out", 32'(sto_reset_o), 32'd1);
        check("s6_level", 32'(fifo_level), 32'd0);
        check("s6_stable", 32'(pio_stable), 32'h00);
        tick(1);
        check("s6_rst_out_lo", 32'(sto_reset_o), 32'd0);
        sto_ready = 1'b1;
        wait_beats("s6_beats", 2);
        check("s6_hdr", 32'(beats[0]), 32'h200);
        check("s6_data", 32'(beats[1]), 32'h109);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
